countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_pkg.sv | 26 ++
 rtl/seg7_decoder.sv | 11 +
 rtl/countdown_timer.sv | 131 +++++++++++++
 tb/tb_countdown_timer.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: state encoding, 7-segment codes
// (active-low, gfedcba) and the default start value.
package countdown_timer_pkg;

  localparam logic [4:0] DefaultMaxSec = 5'd24;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [6:0] SegBlank = 7'h7F;

  // Entry 0 is the rightmost element.
  localparam logic [9:0][6:0] SegTable = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] digit_to_seg(input logic [3:0] digit);
    if (digit > 4'd9) begin
      return SegBlank;
    end
    return SegTable[digit];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-low 7-segment code; non-decimal digits blank.
module seg7_decoder
  import countdown_timer_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = digit_to_seg(digit_i);

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown timer with run/pause/load control, a 1 Hz tick edge detector
// and registered two-digit 7-segment display that blinks "00" once expired.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter logic [4:0] MAX_SEC = DefaultMaxSec
) (
  input  logic       cin,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       start,
  input  logic       pause,
  input  logic       load,
  input  logic [4:0] load_val,
  output logic [4:0] remaining,
  output logic [6:0] hex1,
  output logic [6:0] hex0,
  output logic       running,
  output logic       done
);

  logic [1:0] state_q, state_d;
  logic [4:0] rem_q, rem_d;
  logic [4:0] reload_q, reload_d;
  logic       tick_smp_q, tick_prev_q;
  logic       running_q, done_q;
  logic [6:0] hex1_q, hex1_d;
  logic [6:0] hex0_q, hex0_d;

  logic       tick;
  logic [4:0] load_clamped;
  logic [3:0] tens_digit, ones_digit;
  logic [6:0] tens_seg, ones_seg;

  // Tick fires in the cycle after tick_in is first sampled high.
  assign tick         = tick_smp_q & ~tick_prev_q;
  assign load_clamped = (load_val > MAX_SEC) ? MAX_SEC : load_val;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    if (state_q != StRun && load) begin
      rem_d    = load_clamped;
      reload_d = load_clamped;
      state_d  = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && rem_q != 5'd0) state_d = StRun;
        end
        StRun: begin
          if (tick) begin
            if (rem_q <= 5'd1) begin
              rem_d   = 5'd0;
              state_d = StDone;
            end else begin
              rem_d = rem_q - 5'd1;
              if (pause) state_d = StPause;
            end
          end else if (pause) begin
            state_d = StPause;
          end
        end
        StPause: begin
          if (start) state_d = StRun;
        end
        StDone: begin
          if (start && reload_q != 5'd0) begin
            rem_d   = reload_q;
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tens_digit = 4'(rem_q / 5'd10);
  assign ones_digit = 4'(rem_q % 5'd10);

  seg7_decoder u_seg_tens (
    .digit_i (tens_digit),
    .seg_o   (tens_seg)
  );

  seg7_decoder u_seg_ones (
    .digit_i (ones_digit),
    .seg_o   (ones_seg)
  );

  always_comb begin
    hex1_d = tens_seg;
    hex0_d = ones_seg;
    if (state_q == StDone) begin
      hex1_d = tick_in ? digit_to_seg(4'd0) : SegBlank;
      hex0_d = tick_in ? digit_to_seg(4'd0) : SegBlank;
    end
  end

  always_ff @(posedge cin) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= MAX_SEC;
      reload_q    <= MAX_SEC;
      tick_smp_q  <= 1'b1;
      tick_prev_q <= 1'b1;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      hex1_q      <= digit_to_seg(4'(MAX_SEC / 5'd10));
      hex0_q      <= digit_to_seg(4'(MAX_SEC % 5'd10));
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      reload_q    <= reload_d;
      tick_smp_q  <= tick_in;
      tick_prev_q <= tick_smp_q;
      running_q   <= (state_d == StRun);
      done_q      <= (state_d == StDone);
      hex1_q      <= hex1_d;
      hex0_q      <= hex0_d;
    end
  end

  assign remaining = rem_q;
  assign hex1      = hex1_q;
  assign hex0      = hex0_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random pulses checked
// against a cycle-level behavioural model of the timer rules.
module tb_countdown_timer;

  localparam int MaxSec = 24;
  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MPause = 2;
  localparam int MDone  = 3;

  logic       cin = 1'b0;
  logic       rst = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       load = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic [4:0] remaining;
  logic [6:0] hex1, hex0;
  logic       running, done;

  int checks = 0;
  int errors = 0;

  int         m_mode, m_rem, m_reload;
  bit         m_s1, m_s2;
  logic [6:0] m_hex1, m_hex0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  countdown_timer dut (
    .cin       (cin),
    .rst       (rst),
    .tick_in   (tick_in),
    .start     (start),
    .pause     (pause),
    .load      (load),
    .load_val  (load_val),
    .remaining (remaining),
    .hex1      (hex1),
    .hex0      (hex0),
    .running   (running),
    .done      (done)
  );

  always #10 cin = ~cin;

  // Model of one clock edge; s1/s2 are the last two samples of tick_in.
  function automatic void model_update();
    bit tk;
    if (rst) begin
      m_mode = MIdle; m_rem = MaxSec; m_reload = MaxSec;
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_hex1 = seg_tab[MaxSec / 10];
      m_hex0 = seg_tab[MaxSec % 10];
      return;
    end
    tk = m_s1 && !m_s2;
    if (m_mode == MDone) begin
      m_hex1 = tick_in ? seg_tab[0] : 7'h7F;
      m_hex0 = tick_in ? seg_tab[0] : 7'h7F;
    end else begin
      m_hex1 = seg_tab[m_rem / 10];
      m_hex0 = seg_tab[m_rem % 10];
    end
    if (m_mode == MRun) begin
      if (tk && m_rem > 0) m_rem = m_rem - 1;
      if (m_rem == 0) m_mode = MDone;
      else if (pause) m_mode = MPause;
    end else if (load) begin
      m_rem    = (int'(load_val) > MaxSec) ? MaxSec : int'(load_val);
      m_reload = m_rem;
      m_mode   = MIdle;
    end else if (start) begin
      if (m_mode == MIdle && m_rem > 0) m_mode = MRun;
      else if (m_mode == MPause) m_mode = MRun;
      else if (m_mode == MDone && m_reload > 0) begin
        m_rem  = m_reload;
        m_mode = MRun;
      end
    end
    m_s2 = m_s1;
    m_s1 = tick_in;
  endfunction

  task automatic step();
    @(posedge cin);
    model_update();
    #1;
  endtask

  task automatic pulse_tick();
    tick_in = 1'b1;
    step();
    step();
    tick_in = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [4:0] v);
    load_val = v;
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick_in = 1'b0;
    do_reset();
    checks++;
    if (remaining !== 5'd24) begin
      errors++; $display("FAIL reset_rem: got %0d want 24", remaining);
    end
    checks++;
    if (running !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got running=%b done=%b want 0 0", running, done);
    end
    checks++;
    if (hex1 !== 7'h24 || hex0 !== 7'h19) begin
      errors++; $display("FAIL reset_hex: got %h/%h want 24/19", hex1, hex0);
    end
    step();
    checks++;
    if (remaining !== 5'd24) begin
      errors++; $display("FAIL reset_idle_hold: got %0d want 24", remaining);
    end
  endtask

  task automatic test_basic_countdown();
    do_start();
    checks++;
    if (running !== 1'b1 || remaining !== 5'd24) begin
      errors++; $display("FAIL basic_start: got running=%b rem=%0d want 1 24", running, remaining);
    end
    tick_in = 1'b1;
    step();
    step();
    checks++;
    if (remaining !== 5'd23 || hex1 !== 7'h24 || hex0 !== 7'h19) begin
      errors++;
      $display("FAIL basic_first_tick: got rem=%0d hex=%h/%h want 23 24/19", remaining, hex1, hex0);
    end
    tick_in = 1'b0;
    step();
    checks++;
    if (hex1 !== 7'h24 || hex0 !== 7'h30) begin
      errors++; $display("FAIL basic_hex_lag: got %h/%h want 24/30", hex1, hex0);
    end
    pulse_tick();
    pulse_tick();
    checks++;
    if (remaining !== 5'd21) begin
      errors++; $display("FAIL basic_three_ticks: got %0d want 21", remaining);
    end
  endtask

  task automatic test_load_clamp_done();
    do_reset();
    do_load(5'd31);
    checks++;
    if (remaining !== 5'd24) begin
      errors++; $display("FAIL load_clamp: got %0d want 24", remaining);
    end
    do_load(5'd2);
    do_start();
    pulse_tick();
    checks++;
    if (remaining !== 5'd1 || running !== 1'b1) begin
      errors++; $display("FAIL load_run_one: got rem=%0d running=%b want 1 1", remaining, running);
    end
    pulse_tick();
    checks++;
    if (remaining !== 5'd0 || done !== 1'b1 || running !== 1'b0) begin
      errors++;
      $display("FAIL load_done: got rem=%0d done=%b running=%b want 0 1 0", remaining, done, running);
    end
  endtask

  task automatic test_done_blink();
    step();
    checks++;
    if (hex1 !== 7'h7F || hex0 !== 7'h7F) begin
      errors++; $display("FAIL blink_low: got %h/%h want 7f/7f", hex1, hex0);
    end
    tick_in = 1'b1;
    step();
    checks++;
    if (hex1 !== 7'h40 || hex0 !== 7'h40) begin
      errors++; $display("FAIL blink_high: got %h/%h want 40/40", hex1, hex0);
    end
    tick_in = 1'b0;
    step();
    checks++;
    if (hex1 !== 7'h7F || hex0 !== 7'h7F) begin
      errors++; $display("FAIL blink_low2: got %h/%h want 7f/7f", hex1, hex0);
    end
    do_start();
    checks++;
    if (remaining !== 5'd2 || running !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL done_restart: got rem=%0d running=%b done=%b want 2 1 0", remaining, running, done);
    end
  endtask

  task automatic test_pause();
    do_reset();
    do_load(5'd10);
    do_start();
    tick_in = 1'b1;
    step();
    pause = 1'b1;
    step();
    pause = 1'b0;
    checks++;
    if (remaining !== 5'd9 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL pause_with_tick: got rem=%0d running=%b done=%b want 9 0 0", remaining, running, done);
    end
    tick_in = 1'b0;
    step();
    repeat (5) pulse_tick();
    checks++;
    if (remaining !== 5'd9 || running !== 1'b0) begin
      errors++; $display("FAIL pause_hold: got rem=%0d running=%b want 9 0", remaining, running);
    end
    do_start();
    checks++;
    if (running !== 1'b1 || remaining !== 5'd9) begin
      errors++; $display("FAIL pause_resume: got running=%b rem=%0d want 1 9", running, remaining);
    end
  endtask

  task automatic test_load_start_pause();
    pause = 1'b1;
    step();
    pause = 1'b0;
    load_val = 5'd13;
    load = 1'b1;
    start = 1'b1;
    step();
    load = 1'b0;
    start = 1'b0;
    checks++;
    if (remaining !== 5'd13 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_beats_start: got rem=%0d running=%b done=%b want 13 0 0",
               remaining, running, done);
    end
    step();
    checks++;
    if (hex1 !== 7'h79 || hex0 !== 7'h30) begin
      errors++; $display("FAIL load_hex13: got %h/%h want 79/30", hex1, hex0);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(5'd9);
    do_start();
    pulse_tick();
    pulse_tick();
    checks++;
    if (remaining !== 5'd7) begin
      errors++; $display("FAIL midrun_setup: got %0d want 7", remaining);
    end
    tick_in = 1'b1;
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    rst = 1'b0;
    start = 1'b0;
    checks++;
    if (remaining !== 5'd24 || running !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: got rem=%0d running=%b done=%b want 24 0 0", remaining, running, done);
    end
    do_start();
    step();
    step();
    checks++;
    if (remaining !== 5'd24 || running !== 1'b1) begin
      errors++;
      $display("FAIL midrun_no_tick: got rem=%0d running=%b want 24 1", remaining, running);
    end
    tick_in = 1'b0;
  endtask

  task automatic test_random();
    int tick_cnt = 3;
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 149) == 0);
      load     = ($urandom_range(0, 19) == 0);
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 9) == 0);
      load_val = 5'($urandom_range(0, 31));
      tick_cnt--;
      if (tick_cnt == 0) begin
        tick_in  = ~tick_in;
        tick_cnt = $urandom_range(2, 6);
      end
      step();
      checks++;
      if (remaining !== 5'(m_rem)) begin
        errors++; $display("FAIL rand_rem[%0d]: got %0d want %0d", i, remaining, m_rem);
      end
      checks++;
      if (running !== (m_mode == MRun) || done !== (m_mode == MDone)) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got running=%b done=%b want %b %b", i, running, done,
                 (m_mode == MRun), (m_mode == MDone));
      end
      checks++;
      if (hex1 !== m_hex1 || hex0 !== m_hex0) begin
        errors++;
        $display("FAIL rand_hex[%0d]: got %h/%h want %h/%h", i, hex1, hex0, m_hex1, m_hex0);
      end
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #5;
    test_reset();
    test_basic_countdown();
    test_load_clamp_done();
    test_done_blink();
    test_pause();
    test_load_start_pause();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
